// File: rtl/lmac_gen_pkg.sv
// Shared constants, state encoding and keep helper for the LMAC test-frame generator.
package lmac_gen_pkg;

    localparam int DA_OFF  = 0;
    localparam int SA_OFF  = 6;
    localparam int ET_OFF  = 12;
    localparam int PL_OFF  = 14;
    localparam int HDR_LEN = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_e;

    function automatic logic [3:0] last_keep(input logic [1:0] len_lo);
        case (len_lo)
            2'd0:    return 4'hF;
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

endpackage

// File: rtl/lmac_gen_word.sv
// Combinational beat builder: maps a word index, frame length and sequence seed
// onto the 32-bit AXI-Stream word, its byte-lane keep and the end-of-frame flag.
module lmac_gen_word
    import lmac_gen_pkg::*;
#(
    parameter logic [47:0] DA    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SA    = 48'h000A_3500_0001,
    parameter logic [15:0] ETYPE = 16'h88B5
) (
    input  logic [8:0]  word_idx,
    input  logic [10:0] len,
    input  logic [7:0]  seq,
    output logic [31:0] tdata,
    output logic [3:0]  tkeep,
    output logic        tlast
);

    logic [11:0] len_w;
    logic [11:0] n_words;
    logic [11:0] k;
    logic [11:0] pl;
    int          ki;

    always_comb begin
        len_w   = {1'b0, len};
        n_words = (len_w + 12'd3) >> 2;
        tlast   = ({3'b000, word_idx} == (n_words - 12'd1));
        tkeep   = tlast ? last_keep(len[1:0]) : 4'hF;
        tdata   = '0;
        k       = '0;
        pl      = '0;
        ki      = 0;
        for (int n = 0; n < 4; n++) begin
            k  = {1'b0, word_idx, 2'b00} + 12'(n);
            ki = int'(k);
            pl = k - 12'(HDR_LEN);
            // Lanes beyond the frame length stay zero.
            if (k < len_w) begin
                if (ki < SA_OFF)
                    tdata[8*n +: 8] = DA[8*(SA_OFF - 1 - (ki - DA_OFF)) +: 8];
                else if (ki < ET_OFF)
                    tdata[8*n +: 8] = SA[8*(ET_OFF - 1 - ki) +: 8];
                else if (ki < PL_OFF)
                    tdata[8*n +: 8] = ETYPE[8*(PL_OFF - 1 - ki) +: 8];
                else
                    tdata[8*n +: 8] = pl[7:0] + seq;
            end
        end
    end

endmodule

// File: rtl/lmac_axis_frame_gen.sv
// Programmable Ethernet test-frame source feeding the LMAC TX user AXI-Stream
// port: run control, frame/gap counters and registered stream outputs.
module lmac_axis_frame_gen
    import lmac_gen_pkg::*;
#(
    parameter int          MIN_LEN = 60,
    parameter int          MAX_LEN = 1514,
    parameter logic [47:0] DA      = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SA      = 48'h000A_3500_0001,
    parameter logic [15:0] ETYPE   = 16'h88B5
) (
    input  logic        dclk,
    input  logic        rst_,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] frame_len,
    input  logic [15:0] frame_cnt,
    input  logic [7:0]  ifg,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast
);

    gen_state_e  state_q, state_d;
    logic        busy_q, busy_d;
    logic [15:0] fs_q, fs_d;
    logic [7:0]  seq_q, seq_d;
    logic [8:0]  word_q, word_d;
    logic [7:0]  gap_q, gap_d;
    logic [10:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  ifg_q, ifg_d;
    logic        stop_pend_q, stop_pend_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic [3:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;

    logic        accept;
    logic        last_acc;
    logic        run_done;
    logic [31:0] gen_tdata;
    logic [3:0]  gen_tkeep;
    logic        gen_tlast;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        fs_d        = fs_q;
        seq_d       = seq_q;
        word_d      = word_q;
        gap_d       = gap_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ifg_d       = ifg_q;
        stop_pend_d = stop_pend_q;
        tvalid_d    = tvalid_q;
        accept      = tvalid_q & m_axis_tready;
        last_acc    = accept & tlast_q;
        run_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len < 11'(MIN_LEN))
                        len_d = 11'(MIN_LEN);
                    else if (frame_len > 11'(MAX_LEN))
                        len_d = 11'(MAX_LEN);
                    else
                        len_d = frame_len;
                    cnt_d       = frame_cnt;
                    ifg_d       = ifg;
                    fs_d        = '0;
                    seq_d       = '0;
                    word_d      = '0;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    tvalid_d    = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (stop)
                    stop_pend_d = 1'b1;
                if (last_acc) begin
                    fs_d     = fs_q + 16'd1;
                    seq_d    = seq_q + 8'd1;
                    word_d   = '0;
                    run_done = stop_pend_q | stop | ((cnt_q != 16'd0) && (fs_d == cnt_q));
                    if (run_done) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        tvalid_d    = 1'b0;
                        stop_pend_d = 1'b0;
                    end else if (ifg_q != 8'd0) begin
                        // Load ifg-1 so the gap counter ends at zero after ifg idle cycles.
                        state_d  = GAP;
                        gap_d    = ifg_q - 8'd1;
                        tvalid_d = 1'b0;
                    end
                end else if (accept) begin
                    word_d = word_q + 9'd1;
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    stop_pend_d = 1'b0;
                end else if (gap_q == 8'd0) begin
                    state_d  = SEND;
                    word_d   = '0;
                    tvalid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lmac_gen_word #(
        .DA    (DA),
        .SA    (SA),
        .ETYPE (ETYPE)
    ) u_word (
        .word_idx (word_d),
        .len      (len_d),
        .seq      (seq_d),
        .tdata    (gen_tdata),
        .tkeep    (gen_tkeep),
        .tlast    (gen_tlast)
    );

    always_comb begin
        tdata_d = tvalid_d ? gen_tdata : 32'd0;
        tkeep_d = tvalid_d ? gen_tkeep : 4'd0;
        tlast_d = tvalid_d & gen_tlast;
    end

    always_ff @(posedge dclk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            fs_q        <= '0;
            seq_q       <= '0;
            word_q      <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            ifg_q       <= '0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            fs_q        <= fs_d;
            seq_q       <= seq_d;
            word_q      <= word_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ifg_q       <= ifg_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    assign busy          = busy_q;
    assign frames_sent   = fs_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: doc/lmac_axis_frame_gen.md
Name: lmac_axis_frame_gen

Overview:
- Programmable Ethernet test-frame source.
- Drives the 32-bit TX user AXI-Stream input (s_axis_*) of LMAC_DFIFO_TOP on the dclk (DMA, 50 MHz) domain.
- Builds each frame from a fixed DA/SA/EtherType header plus an incrementing payload.
- Supports frame count, inter-frame gap and graceful stop, for bring-up and loopback testing of the LMAC TX path.

Parameters:
- MIN_LEN, 60, minimum frame length in bytes, excluding FCS.
- MAX_LEN, 1514, maximum frame length in bytes, excluding FCS.
- DA, 48'hFFFF_FFFF_FFFF, destination MAC; byte 0 is bits [47:40].
- SA, 48'h000A_3500_0001, source MAC; byte 0 is bits [47:40].
- ETYPE, 16'h88B5, EtherType; byte 12 is bits [15:8].

Ports:
- dclk  in  1  DMA clock; all logic on rising edge.
- rst_  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  pulse; requests end of run at the next frame boundary.
- frame_len  in  11  frame length in bytes; latched at start.
- frame_cnt  in  16  frames per run; latched at start; 0 = continuous.
- ifg  in  8  idle dclk cycles between frames; latched at start.
- busy  out  1  high while a run is active.
- frames_sent  out  16  frames fully accepted in the current run.
- m_axis_tvalid  out  1  to s_axis_tvalid.
- m_axis_tready  in  1  from s_axis_tready.
- m_axis_tdata  out  32  byte n of a word is on [8n+7:8n].
- m_axis_tkeep  out  4  one bit per byte lane.
- m_axis_tlast  out  1  marks the last word of a frame.

Behaviour:
- Clock and reset: single clock dclk; reset rst_ is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; latched config cleared.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On start, latch config and clamp length: L = MIN_LEN if frame_len < MIN_LEN; L = MAX_LEN if frame_len > MAX_LEN.
  - Clear frames_sent and seq; set busy; go to SEND.
  - Latency: start in cycle N gives tvalid=1 with word 0 in cycle N+1.
- SEND:
  - Frame has W = ceil(L/4) words, word index w = 0..W-1. Byte k = 4w+n.
  - Bytes 0-5 = DA, 6-11 = SA, 12-13 = ETYPE, k>=14 = (k-14+seq) mod 256.
  - tkeep = 4'hF except the last word: L mod 4 of 0/1/2/3 gives F/1/3/7. Unused lanes drive 0.
  - tlast is high only on word W-1.
  - A beat is accepted when tvalid & tready. tdata/tkeep/tlast stay stable while tvalid & !tready.
  - tvalid never drops mid-frame.
- Last beat accepted:
  - frames_sent+1 (wraps at 16 bits); seq+1 (8-bit wrap).
  - If stop is pending, or frame_cnt != 0 and frames_sent+1 == frame_cnt: go to IDLE, busy=0 next cycle.
  - Else if ifg == 0: stay in SEND; word 0 of the next frame is on the next cycle (back-to-back).
  - Else go to GAP.
- GAP:
  - tvalid = 0 for exactly ifg cycles, then SEND.
  - stop during GAP: go to IDLE on the next cycle.
- stop handling:
  - Sticky stop_pend flag; it never truncates a frame.
  - stop in IDLE is ignored.
  - stop and the last beat in the same cycle: the run ends after that frame.
- start while busy: ignored; latched config is unchanged.
- Reset mid-frame: tvalid drops immediately (async). No partial-frame recovery; downstream sees a truncated stream.
- Counters:
  - Word counter is 9 bits; max W = 379.
  - GAP counter is 8 bits; counts down to 0.

Decomposition:
- Package lmac_gen_pkg holds:
  - Constants: header offsets 0/6/12/14, HDR_LEN=14.
  - State enum: IDLE/SEND/GAP.
  - Function last_keep(len[1:0]).
- Sub-module lmac_gen_word: combinational; takes word index, L, seq and header params; returns tdata, tkeep, tlast.
- The top holds the FSM, counters and output registers.

Test Plan:
- Single frame: frame_len=60, frame_cnt=1, tready=1.
  - 15 beats. word0 = 32'hFFFFFFFF, word1 = 32'h0A00FFFF, word3 = 32'h0100B588.
  - Last beat tkeep = F, tlast = 1. frames_sent = 1, busy falls.
- Length 61, frame_cnt=2, ifg=3.
  - 16 beats, last tkeep = 4'h1. Exactly 3 idle cycles between frames.
  - Frame 2 payload starts at 0x01.
- Clamping: frame_len=10 gives 15 beats. frame_len=2000 gives 379 beats with last tkeep = 4'h3.
- Random tready backpressure, 50%, frame_len=100.
  - tdata/tkeep/tlast stable while stalled. Byte sequence matches the formula. 25 beats accepted.
- frame_cnt=0, ifg=0, stop asserted at word 7 of frame 3.
  - Back-to-back frames; frame 3 completes fully. frames_sent = 3, then IDLE.
- rst_ low at word 5: all outputs 0 asynchronously.
  - A new start after rst_ high produces frame with seq 0.
